// File: rtl/fifo_pkg.sv
// Shared FIFO helpers: Gray/binary conversion and depth derivation.
// Functions work on a 32-bit container; callers zero-extend narrower pointers.
package fifo_pkg;

    localparam int PTR_CONTAINER_W = 32;

    function automatic int fifo_depth(input int addr_size);
        return 1 << addr_size;
    endfunction

    function automatic logic [PTR_CONTAINER_W-1:0] bin2gray(
        input logic [PTR_CONTAINER_W-1:0] bin
    );
        return bin ^ (bin >> 1);
    endfunction

    // Zero-extended inputs stay correct: leading zeros propagate as zeros.
    function automatic logic [PTR_CONTAINER_W-1:0] gray2bin(
        input logic [PTR_CONTAINER_W-1:0] gray
    );
        logic [PTR_CONTAINER_W-1:0] bin;
        bin[PTR_CONTAINER_W-1] = gray[PTR_CONTAINER_W-1];
        for (int i = PTR_CONTAINER_W-2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/gray2bin_conv.sv
// Combinational Gray-to-binary converter for a W-bit pointer.
module gray2bin_conv
    import fifo_pkg::*;
#(
    parameter int W = 5
) (
    input  logic [W-1:0] gray,
    output logic [W-1:0] bin
);

    logic [PTR_CONTAINER_W-1:0] bin_wide;

    assign bin_wide = gray2bin(PTR_CONTAINER_W'(gray));
    assign bin      = bin_wide[W-1:0];

endmodule

// File: rtl/wr_ptr_full_ctrl.sv
// Write-side pointer and full/overflow control for an async FIFO.
// Optional occupancy and almost-full outputs are built with WR_ALMOST_FULL_EN.
module wr_ptr_full_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDR_SIZE    = 4,
    parameter int AFULL_THRESH = 2
) (
    input  logic                 wr_clk,
    input  logic                 wr_rstn,
    input  logic                 wr_en,
    input  logic [ADDR_SIZE:0]   wrq2_rptr,
    output logic [ADDR_SIZE-1:0] wr_addr,
    output logic [ADDR_SIZE:0]   wr_ptr,
    output logic                 wr_full,
    output logic                 wr_overflow,
    output logic                 wr_almost_full,
    output logic [ADDR_SIZE:0]   wr_count
);

    localparam int PW    = ADDR_SIZE + 1;
    localparam int DEPTH = fifo_depth(ADDR_SIZE);

    logic                       wr_inc;
    logic [PW-1:0]              wbin;
    logic [PW-1:0]              wbin_next;
    logic [PTR_CONTAINER_W-1:0] wgray_wide;
    logic [PW-1:0]              wgray_next;
    logic [PW-1:0]              full_match;

    assign wr_inc     = wr_en & ~wr_full;
    assign wbin_next  = wbin + {{(PW-1){1'b0}}, wr_inc};
    assign wgray_wide = bin2gray(PTR_CONTAINER_W'(wbin_next));
    assign wgray_next = wgray_wide[PW-1:0];
    assign wr_addr    = wbin[ADDR_SIZE-1:0];

    // Full when the write pointer is exactly one lap ahead of the read pointer.
    assign full_match = {~wrq2_rptr[ADDR_SIZE:ADDR_SIZE-1], wrq2_rptr[ADDR_SIZE-2:0]};

    always_ff @(posedge wr_clk or negedge wr_rstn) begin
        if (!wr_rstn) begin
            wbin        <= '0;
            wr_ptr      <= '0;
            wr_full     <= 1'b0;
            wr_overflow <= 1'b0;
        end else begin
            wbin        <= wbin_next;
            wr_ptr      <= wgray_next;
            wr_full     <= (wgray_next == full_match);
            wr_overflow <= wr_overflow | (wr_en & wr_full);
        end
    end

`ifdef WR_ALMOST_FULL_EN
    logic [PW-1:0] rbin;
    logic [PW-1:0] occ_next;
    logic [PW:0]   free_next;

    gray2bin_conv #(
        .W (PW)
    ) u_rptr_conv (
        .gray (wrq2_rptr),
        .bin  (rbin)
    );

    assign occ_next  = wbin_next - rbin;
    assign free_next = (PW+1)'(DEPTH) - {1'b0, occ_next};

    always_ff @(posedge wr_clk or negedge wr_rstn) begin
        if (!wr_rstn) begin
            wr_count       <= '0;
            wr_almost_full <= 1'b0;
        end else begin
            wr_count       <= occ_next;
            wr_almost_full <= (free_next <= (PW+1)'(AFULL_THRESH));
        end
    end
`else
    assign wr_count       = '0;
    assign wr_almost_full = 1'b0;
`endif

endmodule
